// File: rtl/master_slave_jk_bank.sv
// rtl/master_slave_jk_bank.sv - bank of independent master-slave JK/T/D bit-slices
// Master captures on enabled edges; slave copies the master one edge later.
module master_slave_jk_bank #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q_m,
  output logic [WIDTH-1:0] q_s,
  output logic [WIDTH-1:0] q_s_bar,
  output logic             vld,
  output logic             chg
);

  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_T    = 2'b01;
  localparam logic [1:0] MODE_D    = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  logic [WIDTH-1:0] q_m_q, q_m_d;
  logic [WIDTH-1:0] q_s_q, q_s_d;
  logic             pend_q, pend_d;
  logic             vld_q, vld_d;
  logic             chg_q, chg_d;
  logic [WIDTH-1:0] m_next;
  logic             upd;

  always_comb begin
    m_next = q_m_q;
    case (mode)
      MODE_JK:   m_next = (j & ~q_m_q) | (~k & q_m_q);
      MODE_T:    m_next = q_m_q ^ j;
      MODE_D:    m_next = j;
      MODE_HOLD: m_next = q_m_q;
      default:   m_next = q_m_q;
    endcase
  end

  assign upd = en && (mode != MODE_HOLD);

  // Slave always takes the pre-edge master, so an update and a transfer can share one edge.
  always_comb begin
    q_m_d  = upd ? m_next : q_m_q;
    q_s_d  = pend_q ? q_m_q : q_s_q;
    pend_d = upd;
    vld_d  = pend_q;
    chg_d  = pend_q && (q_m_q != q_s_q);
  end

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      q_m_q  <= RST_VAL;
      q_s_q  <= RST_VAL;
      pend_q <= 1'b0;
      vld_q  <= 1'b0;
      chg_q  <= 1'b0;
    end else begin
      q_m_q  <= q_m_d;
      q_s_q  <= q_s_d;
      pend_q <= pend_d;
      vld_q  <= vld_d;
      chg_q  <= chg_d;
    end
  end

  assign q_m     = q_m_q;
  assign q_s     = q_s_q;
  assign q_s_bar = ~q_s_q;
  assign vld     = vld_q;
  assign chg     = chg_q;

endmodule

// File: tb/tb_master_slave_jk_bank.sv
// tb/tb_master_slave_jk_bank.sv - randomized and directed bench for master_slave_jk_bank
// Reference model tracks master/slave contents as plain values updated per clock.
module tb_master_slave_jk_bank;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, en, clr;
  logic [1:0]   mode;
  logic [W-1:0] j, k;
  logic [W-1:0] q_m, q_s, q_s_bar;
  logic         vld, chg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] mdl_m, mdl_s;
  logic         mdl_pend, mdl_vld, mdl_chg;

  always #5 clk = ~clk;

  master_slave_jk_bank #(.WIDTH(W), .RST_VAL('0)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .j(j), .k(k),
    .q_m(q_m), .q_s(q_s), .q_s_bar(q_s_bar), .vld(vld), .chg(chg)
  );

  function automatic logic [W-1:0] apply_rule(input logic [W-1:0] cur, input logic [1:0] md,
                                               input logic [W-1:0] jv, input logic [W-1:0] kv);
    logic [W-1:0] r;
    r = cur;
    for (int i = 0; i < W; i++) begin
      if (md == 2'd0) begin
        if (jv[i] && kv[i])  r[i] = ~cur[i];
        else if (jv[i])      r[i] = 1'b1;
        else if (kv[i])      r[i] = 1'b0;
      end else if (md == 2'd1) begin
        r[i] = (cur[i] + jv[i]) % 2;
      end else if (md == 2'd2) begin
        r[i] = jv[i];
      end
    end
    return r;
  endfunction

  task automatic cycle();
    logic [W-1:0] nm, ns;
    logic np, nv, nc;
    if (!rst || clr) begin
      nm = '0; ns = '0; np = 1'b0; nv = 1'b0; nc = 1'b0;
    end else begin
      np = en && (mode != 2'd3);
      nm = np ? apply_rule(mdl_m, mode, j, k) : mdl_m;
      ns = mdl_pend ? mdl_m : mdl_s;
      nv = mdl_pend;
      nc = mdl_pend && (mdl_m != mdl_s);
    end
    @(posedge clk);
    #1;
    mdl_m = nm; mdl_s = ns; mdl_pend = np; mdl_vld = nv; mdl_chg = nc;
  endtask

  task automatic drive(input logic r, input logic e, input logic c, input logic [1:0] md,
                       input logic [W-1:0] jv, input logic [W-1:0] kv);
    rst = r; en = e; clr = c; mode = md; j = jv; k = kv;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 1'b0, 2'd2, 4'b1111, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      if (c == 2) drive(1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
      cycle();
      n_checks++;
      if ({q_m, q_s, q_s_bar, vld, chg} !== {4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset[%0d]: q_m=%b q_s=%b q_s_bar=%b vld=%b chg=%b required 0000 0000 1111 0 0",
                 c, q_m, q_s, q_s_bar, vld, chg);
      end
    end
  endtask

  task automatic test_jk_pulse();
    logic [W-1:0] exp_m [3] = '{4'b1010, 4'b1010, 4'b1010};
    logic [W-1:0] exp_s [3] = '{4'b0000, 4'b1010, 4'b1010};
    logic         exp_v [3] = '{1'b0, 1'b1, 1'b0};
    logic         exp_c [3] = '{1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, c == 0, 1'b0, 2'd0, 4'b1010, 4'b0101);
      cycle();
      n_checks++;
      if ({q_m, q_s, vld, chg} !== {exp_m[c], exp_s[c], exp_v[c], exp_c[c]}) begin
        n_fail++;
        $display("FAIL jk_pulse[%0d]: q_m=%b q_s=%b vld=%b chg=%b required %b %b %b %b",
                 c, q_m, q_s, vld, chg, exp_m[c], exp_s[c], exp_v[c], exp_c[c]);
      end
    end
  endtask

  task automatic test_jk_toggle();
    logic [W-1:0] exp_m [4] = '{4'b0101, 4'b1010, 4'b0101, 4'b0101};
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, c < 3, 1'b0, 2'd0, 4'b1111, 4'b1111);
      cycle();
      n_checks++;
      if ({q_m, q_s, vld, chg} !== {exp_m[c], mdl_s, mdl_vld, mdl_chg} || vld !== (c > 0)) begin
        n_fail++;
        $display("FAIL jk_toggle[%0d]: q_m=%b q_s=%b vld=%b chg=%b required %b %b %b %b",
                 c, q_m, q_s, vld, chg, exp_m[c], mdl_s, mdl_vld, mdl_chg);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]   md    [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [W-1:0] jv    [4] = '{4'b0000, 4'b0011, 4'b1100, 4'b0000};
    logic [W-1:0] exp_m [4] = '{4'b0000, 4'b0011, 4'b1100, 4'b1100};
    logic [W-1:0] exp_s [4] = '{4'b0000, 4'b0000, 4'b0011, 4'b1100};
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, c == 1 || c == 2, c == 0, md[c], jv[c], 4'b0000);
      cycle();
      n_checks++;
      if ({q_m, q_s, vld, chg} !== {exp_m[c], exp_s[c], mdl_vld, mdl_chg}) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: q_m=%b q_s=%b vld=%b chg=%b required %b %b %b %b",
                 c, q_m, q_s, vld, chg, exp_m[c], exp_s[c], mdl_vld, mdl_chg);
      end
    end
  endtask

  task automatic test_clr_priority();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, c < 2, c == 1, 2'd2, 4'b0110, 4'b0000);
      cycle();
      n_checks++;
      if ({q_m, q_s, vld, chg} !== {mdl_m, mdl_s, mdl_vld, mdl_chg} ||
          (c > 0 && {q_m, q_s, vld} !== 9'b0)) begin
        n_fail++;
        $display("FAIL clr_priority[%0d]: q_m=%b q_s=%b vld=%b chg=%b required %b %b %b %b",
                 c, q_m, q_s, vld, chg, mdl_m, mdl_s, mdl_vld, mdl_chg);
      end
    end
  endtask

  task automatic test_hold_and_reset_pending();
    // hold-mode pulse, then D update cancelled by reset, then idle cycles
    logic         r  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic         e  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0]   md [6] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0};
    for (int c = 0; c < 6; c++) begin
      drive(r[c], e[c], 1'b0, md[c], 4'b1111, 4'b1111);
      cycle();
      n_checks++;
      if ({q_m, q_s, vld, chg} !== {mdl_m, mdl_s, mdl_vld, mdl_chg} || vld !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_reset_pending[%0d]: q_m=%b q_s=%b vld=%b chg=%b required %b %b 0 %b",
                 c, q_m, q_s, vld, chg, mdl_m, mdl_s, mdl_chg);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 31) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
            2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
      cycle();
      n_checks++;
      if ({q_m, q_s, q_s_bar, vld, chg} !== {mdl_m, mdl_s, ~mdl_s, mdl_vld, mdl_chg}) begin
        n_fail++;
        $display("FAIL random[%0d]: q_m=%b q_s=%b q_s_bar=%b vld=%b chg=%b required %b %b %b %b %b",
                 c, q_m, q_s, q_s_bar, vld, chg, mdl_m, mdl_s, ~mdl_s, mdl_vld, mdl_chg);
      end
    end
  endtask

  initial begin
    mdl_m = '0; mdl_s = '0; mdl_pend = 1'b0; mdl_vld = 1'b0; mdl_chg = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'd0, '0, '0);
    test_reset();
    test_jk_pulse();
    test_jk_toggle();
    test_back_to_back();
    test_clr_priority();
    test_hold_and_reset_pending();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/master_slave_jk_bank.md
MASTER_SLAVE_JK_BANK -- requirements
Module: master_slave_jk_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of independent JK bit-slices (legal range 1..32).
REQ-002 SHALL have parameter RST_VAL, default {WIDTH{1'b0}}, value loaded into master and slave stages by reset and clear.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-005 SHALL have port en, input, 1, master-stage update enable.
REQ-006 SHALL have port clr, input, 1, synchronous clear of both stages to RST_VAL.
REQ-007 SHALL have port mode, input, 2, 00=JK, 01=T (j is t), 10=D (j is d), 11=hold.
REQ-008 SHALL have port j, input, WIDTH, per-bit J / T / D input.
REQ-009 SHALL have port k, input, WIDTH, per-bit K input; ignored outside JK mode.
REQ-010 SHALL have port q_m, output, WIDTH, master-stage state.
REQ-011 SHALL have port q_s, output, WIDTH, slave-stage state (block output).
REQ-012 SHALL have port q_s_bar, output, WIDTH, bitwise inverse of q_s, combinational.
REQ-013 SHALL have port vld, output, 1, high for each cycle in which q_s was updated by the preceding edge.
REQ-014 SHALL have port chg, output, 1, high when that update changed at least one bit of q_s.

Function
REQ-015 SHALL update q_m at a rising edge only when rst=1, clr=0, en=1 and mode!=11; otherwise q_m holds.
REQ-016 SHALL in JK mode compute per bit from current q_m: 00 hold, 01 -> 0, 10 -> 1, 11 -> ~q_m.
REQ-017 SHALL in T mode set q_m[i] <= q_m[i] ^ j[i].
REQ-018 SHALL in D mode set q_m[i] <= j[i].
REQ-019 SHALL keep an internal pending flag, set on every edge where REQ-015 updates q_m, cleared otherwise.
REQ-020 SHALL at any edge where pending=1 (and rst=1, clr=0) transfer q_s <= q_m (pre-edge value); q_s otherwise holds.
REQ-021 SHALL give latency 1 cycle inputs->q_m and 2 cycles inputs->q_s; with en held high q_s lags q_m by exactly one cycle.
REQ-022 SHALL register vld <= pending and chg <= pending & (q_m != q_s) at each edge, so both reflect the transfer just performed.
REQ-023 SHALL give clr priority over en: clr=1 loads q_m=q_s=RST_VAL, clears pending, vld=0, chg=0 next cycle.
REQ-024 SHALL, on en=1 coinciding with a pending transfer, perform both in the same edge: q_s takes the old q_m, q_m takes the new value.
REQ-025 SHALL treat an en=1 with mode=11 as no update: pending not set, no later vld.
REQ-026 SHALL report vld=1 with chg=0 when the transferred value equals the prior q_s (e.g. JK 00 on all bits).
REQ-027 SHALL keep each bit-slice independent; no cross-bit carry or interaction.

Reset
REQ-028 SHALL, when rst=0 at a rising edge, load q_m=q_s=RST_VAL and clear pending, vld and chg, regardless of en, clr or mode.
REQ-029 SHALL, on reset asserted mid-operation, discard any pending transfer; first vld after release requires a new enabled update.
REQ-030 SHALL leave q_s_bar = ~RST_VAL throughout reset.

Verification (WIDTH=4, RST_VAL=0)
REQ-031 SHALL cover: rst=0 two cycles, then release with en=0 -> q_m=q_s=0000, q_s_bar=1111, vld=0, chg=0.
REQ-032 SHALL cover: mode=00, j=1010,k=0101, en pulse one cycle -> q_m=1010 after edge 1; q_s=1010, vld=1, chg=1 after edge 2; vld=0 after edge 3.
REQ-033 SHALL cover: from q_m=q_s=1010, mode=00, j=k=1111, en held high 3 cycles -> q_m 0101,1010,0101; q_s 1010(chg=0),0101,1010; vld=1 on edges 2-4.
REQ-034 SHALL cover: mode=01 j=0011 then mode=10 j=1100 back-to-back from 0000 -> q_m 0011 then 1100; q_s 0011 then 1100 one cycle later.
REQ-035 SHALL cover: clr=1 and en=1 same edge with pending=1 -> q_m=q_s=0000, vld=0, no transfer of old q_m.
REQ-036 SHALL cover: en pulse with mode=11 -> q_m unchanged, no vld; rst=0 during pending -> vld never asserts for that update.
